engine_rr_arbiter: RTL and testbench
====================================

Name: engine_rr_arbiter

Overview:
- Round-robin arbiter and sequencer that shares one multi-cycle engine (a small FSM datapath with a start/done handshake) between NUM_REQ requesters.
- Grants one requester at a time, pulses the engine start, and waits for done.
- A watchdog reclaims the engine if done never arrives.
- Sits between requester blocks and the shared engine. The state is exported so formal harnesses can assert and cover on it.

Parameters:
- NUM_REQ, 4: number of requesters; legal range 2..16.
- TIMEOUT, 15: maximum RUN cycles allowed before a forced release; legal range 1..255.
- IDX_W, $clog2(NUM_REQ): width of grant index. Derived; not to be overridden.

Ports:
- clk  input  1  single clock; all logic on posedge.
- rst  input  1  synchronous, active-high reset.
- req  input  NUM_REQ  per-requester request level.
- gnt  output  NUM_REQ  one-hot grant, registered.
- gnt_idx  output  IDX_W  index of current or last grant.
- gnt_valid  output  1  high while gnt is non-zero.
- eng_start  output  1  one-cycle start pulse to the engine.
- eng_done  input  1  engine completion pulse.
- timeout  output  1  one-cycle pulse on forced release.
- timeout_cnt  output  8  saturating count of timeouts since reset.
- state  output  2  encoded FSM state: IDLE=0, GRANT=1, RUN=2, RELEASE=3.

Behaviour:
- Clock and reset: one clock, clk. Reset rst is synchronous and active-high.
- Reset values, applied on the cycle after rst is sampled high:
  - state=IDLE, gnt=0, gnt_idx=0, gnt_valid=0, eng_start=0, timeout=0, timeout_cnt=0.
  - Round-robin pointer ptr=0; run counter cnt=0.
- Reset mid-operation: abandons any grant immediately. No timeout is counted. Engine completion after reset is ignored.
- IDLE:
  - If req is non-zero, select the first set bit searching ptr, ptr+1, ..., wrapping modulo NUM_REQ.
  - Register gnt (one-hot) and gnt_idx, set gnt_valid=1 and eng_start=1, and go to GRANT.
  - If req is zero, stay in IDLE with all outputs low.
- GRANT:
  - Lasts exactly one cycle; eng_start=1 only in this state. Clear cnt; go to RUN.
  - eng_done in GRANT is ignored, because the engine latency is at least 1 cycle.
- RUN:
  - gnt is held stable regardless of req; dropping req does not abort the grant.
  - eng_done=1: go to RELEASE, no timeout.
  - Otherwise, if cnt==TIMEOUT-1: go to RELEASE and assert timeout=1 in the RELEASE cycle. timeout_cnt increments, saturating at 255.
  - Otherwise cnt increments.
  - eng_done on the same cycle as the timeout limit counts as done; no timeout.
- RELEASE:
  - gnt=0, gnt_valid=0; gnt_idx holds the last winner.
  - ptr = (gnt_idx+1) mod NUM_REQ. Go to IDLE.
- Timing:
  - Minimum turnaround is req (cycle 0) → gnt/start (1) → RUN (2) → done at cycle k ≥ 2 → RELEASE (k+1) → IDLE (k+2).
  - A new grant earliest at k+3.
- Fairness: a continuously asserted requester waits at most NUM_REQ-1 other grants.
- Invariants:
  - gnt is one-hot or zero.
  - gnt_valid equals (state==GRANT or state==RUN).
  - eng_start implies state==GRANT.
  - timeout implies state==RELEASE.

Test Plan:
- Reset and single requester:
  - Stimulus: rst high 2 cycles, then req=4'b0100; eng_done at the 3rd RUN cycle.
  - Required: gnt=0100 and eng_start=1 in cycle 1, state=2 in cycles 2–4, RELEASE in cycle 5, IDLE in cycle 6, timeout_cnt=0.
- Round-robin rotation:
  - Stimulus: req=4'b1111 held; done after 1 RUN cycle each grant.
  - Required: grant order idx 0,1,2,3,0; each grant is 4 cycles apart.
- Timeout:
  - Stimulus: TIMEOUT=15, req=0001, eng_done never asserted.
  - Required: 15 RUN cycles, then timeout=1 for exactly one cycle in RELEASE; timeout_cnt=1; next grant to idx 0 again if it is the only requester.
- Done vs timeout collision:
  - Stimulus: eng_done asserted on RUN cycle 15 (cnt==14).
  - Required: normal release, timeout=0, timeout_cnt unchanged.
- Request drop and reset mid-run:
  - Stimulus: requester 2 granted, req drops in RUN; then rst pulsed in a later RUN cycle.
  - Required: gnt held through the drop. After reset: state=0, gnt=0, ptr=0, and the next req=1111 grants idx 0.
- Saturation:
  - Stimulus: 260 consecutive timeouts.
  - Required: timeout_cnt stops at 255.

Source files
------------

// File: rtl/engine_rr_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : engine_rr_arbiter
//  Description : Round-robin arbiter/sequencer sharing one multi-cycle engine
//                between NUM_REQ requesters. Grants one requester, pulses
//                eng_start, waits for eng_done, and forcibly reclaims the
//                engine through a watchdog if done never arrives.
//  Revision    : 1.0 - initial release
// ============================================================================
module engine_rr_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int TIMEOUT = 15,
    parameter int IDX_W   = $clog2(NUM_REQ)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NUM_REQ-1:0] req,
    output logic [NUM_REQ-1:0] gnt,
    output logic [IDX_W-1:0]   gnt_idx,
    output logic               gnt_valid,
    output logic               eng_start,
    input  logic               eng_done,
    output logic               timeout,
    output logic [7:0]         timeout_cnt,
    output logic [1:0]         state
);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_GRANT   = 2'd1,
        ST_RUN     = 2'd2,
        ST_RELEASE = 2'd3
    } state_t;

    localparam logic [IDX_W:0]     c_num_req   = (IDX_W+1)'(NUM_REQ);
    localparam logic [IDX_W-1:0]   c_last_idx  = IDX_W'(NUM_REQ - 1);
    localparam logic [7:0]         c_cnt_limit = 8'(TIMEOUT - 1);
    localparam logic [7:0]         c_cnt_sat   = 8'hFF;
    localparam logic [NUM_REQ-1:0] c_one_hot0  = NUM_REQ'(1);

    // Registered state and outputs
    state_t             r_state;
    logic [NUM_REQ-1:0] r_gnt;
    logic [IDX_W-1:0]   r_gnt_idx;
    logic               r_gnt_valid;
    logic               r_eng_start;
    logic               r_timeout;
    logic [7:0]         r_timeout_cnt;
    logic [IDX_W-1:0]   r_ptr;
    logic [7:0]         r_cnt;

    // Next-state values
    state_t             w_state_nxt;
    logic [NUM_REQ-1:0] w_gnt_nxt;
    logic [IDX_W-1:0]   w_gnt_idx_nxt;
    logic               w_gnt_valid_nxt;
    logic               w_eng_start_nxt;
    logic               w_timeout_nxt;
    logic [7:0]         w_timeout_cnt_nxt;
    logic [IDX_W-1:0]   w_ptr_nxt;
    logic [7:0]         w_cnt_nxt;

    // Arbitration datapath
    logic [2*NUM_REQ-1:0] w_req_dbl;
    logic [NUM_REQ-1:0]   w_req_rot;
    logic [IDX_W-1:0]     w_offset;
    logic [IDX_W:0]       w_sum;
    logic [IDX_W-1:0]     w_winner;

    // Rotate requests so that bit 0 corresponds to the priority pointer.
    assign w_req_dbl = {req, req};
    assign w_req_rot = NUM_REQ'(w_req_dbl >> r_ptr);

    // Lowest set bit of the rotated vector, then map back to an absolute index.
    always_comb begin
        w_offset = '0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            if (w_req_rot[i]) begin
                w_offset = IDX_W'(i);
            end
        end
        w_sum = {1'b0, r_ptr} + {1'b0, w_offset};
        if (w_sum >= c_num_req) begin
            w_winner = IDX_W'(w_sum - c_num_req);
        end else begin
            w_winner = w_sum[IDX_W-1:0];
        end
    end

    // Next-state and next-output logic for the sequencer.
    always_comb begin
        w_state_nxt       = r_state;
        w_gnt_nxt         = r_gnt;
        w_gnt_idx_nxt     = r_gnt_idx;
        w_gnt_valid_nxt   = r_gnt_valid;
        w_eng_start_nxt   = 1'b0;
        w_timeout_nxt     = 1'b0;
        w_timeout_cnt_nxt = r_timeout_cnt;
        w_ptr_nxt         = r_ptr;
        w_cnt_nxt         = r_cnt;

        case (r_state)
            ST_IDLE: begin
                if (|req) begin
                    w_state_nxt     = ST_GRANT;
                    w_gnt_nxt       = c_one_hot0 << w_winner;
                    w_gnt_idx_nxt   = w_winner;
                    w_gnt_valid_nxt = 1'b1;
                    w_eng_start_nxt = 1'b1;
                end
            end

            // Done is not possible here: engine latency is at least one cycle.
            ST_GRANT: begin
                w_cnt_nxt   = '0;
                w_state_nxt = ST_RUN;
            end

            // Done wins over the watchdog when both land on the same cycle.
            ST_RUN: begin
                if (eng_done) begin
                    w_state_nxt     = ST_RELEASE;
                    w_gnt_nxt       = '0;
                    w_gnt_valid_nxt = 1'b0;
                end else if (r_cnt == c_cnt_limit) begin
                    w_state_nxt     = ST_RELEASE;
                    w_gnt_nxt       = '0;
                    w_gnt_valid_nxt = 1'b0;
                    w_timeout_nxt   = 1'b1;
                    if (r_timeout_cnt != c_cnt_sat) begin
                        w_timeout_cnt_nxt = r_timeout_cnt + 8'd1;
                    end
                end else begin
                    w_cnt_nxt = r_cnt + 8'd1;
                end
            end

            // The requester after the last winner gets top priority next.
            ST_RELEASE: begin
                if (r_gnt_idx == c_last_idx) begin
                    w_ptr_nxt = '0;
                end else begin
                    w_ptr_nxt = r_gnt_idx + IDX_W'(1);
                end
                w_state_nxt = ST_IDLE;
            end

            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // State and output registers; reset abandons any grant in progress.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state       <= ST_IDLE;
            r_gnt         <= '0;
            r_gnt_idx     <= '0;
            r_gnt_valid   <= 1'b0;
            r_eng_start   <= 1'b0;
            r_timeout     <= 1'b0;
            r_timeout_cnt <= '0;
            r_ptr         <= '0;
            r_cnt         <= '0;
        end else begin
            r_state       <= w_state_nxt;
            r_gnt         <= w_gnt_nxt;
            r_gnt_idx     <= w_gnt_idx_nxt;
            r_gnt_valid   <= w_gnt_valid_nxt;
            r_eng_start   <= w_eng_start_nxt;
            r_timeout     <= w_timeout_nxt;
            r_timeout_cnt <= w_timeout_cnt_nxt;
            r_ptr         <= w_ptr_nxt;
            r_cnt         <= w_cnt_nxt;
        end
    end

    assign gnt         = r_gnt;
    assign gnt_idx     = r_gnt_idx;
    assign gnt_valid   = r_gnt_valid;
    assign eng_start   = r_eng_start;
    assign timeout     = r_timeout;
    assign timeout_cnt = r_timeout_cnt;
    assign state       = r_state;

endmodule
`default_nettype wire

// File: tb/tb_engine_rr_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_engine_rr_arbiter
//  Description : Self-checking bench for engine_rr_arbiter. Directed scenarios
//                plus randomized traffic compared every cycle against a
//                behavioural model of the arbiter.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_engine_rr_arbiter;

    localparam int NUM_REQ = 4;
    localparam int TIMEOUT = 15;
    localparam int IDX_W   = $clog2(NUM_REQ);

    logic               clk;
    logic               rst;
    logic [NUM_REQ-1:0] req;
    logic [NUM_REQ-1:0] gnt;
    logic [IDX_W-1:0]   gnt_idx;
    logic               gnt_valid;
    logic               eng_start;
    logic               eng_done;
    logic               timeout;
    logic [7:0]         timeout_cnt;
    logic [1:0]         state;

    engine_rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .TIMEOUT (TIMEOUT)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .req         (req),
        .gnt         (gnt),
        .gnt_idx     (gnt_idx),
        .gnt_valid   (gnt_valid),
        .eng_start   (eng_start),
        .eng_done    (eng_done),
        .timeout     (timeout),
        .timeout_cnt (timeout_cnt),
        .state       (state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    // Behavioural model: phase 0..3, owner, rotation pointer, RUN age.
    int m_phase = 0;
    int m_gnt   = 0;
    int m_idx   = 0;
    int m_valid = 0;
    int m_start = 0;
    int m_to    = 0;
    int m_tocnt = 0;
    int m_ptr   = 0;
    int m_age   = 0;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    task automatic model_release();
        m_phase = 3;
        m_gnt   = 0;
        m_valid = 0;
    endtask

    task automatic model_step(input logic rs, input logic [NUM_REQ-1:0] rq, input logic dn);
        int win;
        if (rs) begin
            m_phase = 0; m_gnt = 0; m_idx = 0; m_valid = 0; m_start = 0;
            m_to = 0; m_tocnt = 0; m_ptr = 0; m_age = 0;
        end else begin
            m_start = 0;
            m_to    = 0;
            case (m_phase)
                0: begin
                    win = -1;
                    for (int k = 0; k < NUM_REQ; k++) begin
                        if (win < 0 && rq[(m_ptr + k) % NUM_REQ]) win = (m_ptr + k) % NUM_REQ;
                    end
                    if (win >= 0) begin
                        m_phase = 1; m_gnt = 1 << win; m_idx = win;
                        m_valid = 1; m_start = 1;
                    end
                end
                1: begin
                    m_age   = 0;
                    m_phase = 2;
                end
                2: begin
                    m_age++;
                    if (dn) begin
                        model_release();
                    end else if (m_age == TIMEOUT) begin
                        model_release();
                        m_to = 1;
                        if (m_tocnt < 255) m_tocnt++;
                    end
                end
                default: begin
                    m_ptr   = (m_idx + 1) % NUM_REQ;
                    m_phase = 0;
                end
            endcase
        end
    endtask

    // One clock: advance model on the edge, compare DUT just after it.
    task automatic tick();
        @(posedge clk);
        model_step(rst, req, eng_done);
        #1;
        cyc++;
        check_eq("state",       32'(state),       m_phase);
        check_eq("gnt",         32'(gnt),         m_gnt);
        check_eq("gnt_idx",     32'(gnt_idx),     m_idx);
        check_eq("gnt_valid",   32'(gnt_valid),   m_valid);
        check_eq("eng_start",   32'(eng_start),   m_start);
        check_eq("timeout",     32'(timeout),     m_to);
        check_eq("timeout_cnt", 32'(timeout_cnt), m_tocnt);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    // Hard stop in case the bench itself wedges.
    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, checks=%0d", n_checks);
        $fatal(1, "watchdog");
    end

    initial begin
        int rr_idx[5];
        int rr_cyc[5];
        int rr_n;
        int runs;
        int tpulses;
        int regrant;
        int exp_rr[5];
        int guard;

        exp_rr = '{0, 1, 2, 3, 0};
        rst = 1'b1; req = '0; eng_done = 1'b0;

        // Reset and single requester
        tick(); tick();
        check_eq("rst_state", 32'(state), 0);
        check_eq("rst_gnt", 32'(gnt), 0);
        check_eq("rst_tocnt", 32'(timeout_cnt), 0);
        rst = 1'b0; req = 4'b0100;
        tick();
        check_eq("single_gnt", 32'(gnt), 32'h4);
        check_eq("single_start", 32'(eng_start), 1);
        req = '0;
        tick(); check_eq("single_run1", 32'(state), 2);
        tick(); check_eq("single_run2", 32'(state), 2);
        tick(); check_eq("single_run3", 32'(state), 2);
        eng_done = 1'b1;
        tick(); check_eq("single_rel", 32'(state), 3);
        eng_done = 1'b0;
        tick(); check_eq("single_idle", 32'(state), 0);
        check_eq("single_tocnt", 32'(timeout_cnt), 0);

        // Round-robin rotation with all requesters active
        do_reset();
        req = 4'b1111; rr_n = 0;
        for (int t = 0; t < 40 && rr_n < 5; t++) begin
            eng_done = (m_phase == 2);
            tick();
            if (eng_start) begin
                rr_idx[rr_n] = int'(gnt_idx);
                rr_cyc[rr_n] = cyc;
                rr_n++;
            end
        end
        eng_done = 1'b0;
        check_eq("rr_count", rr_n, 5);
        for (int i = 0; i < rr_n; i++) begin
            check_eq("rr_order", rr_idx[i], exp_rr[i]);
            if (i > 0) check_eq("rr_gap", rr_cyc[i] - rr_cyc[i-1], 4);
        end

        // Timeout with a lone requester that is never completed
        do_reset();
        req = 4'b0001;
        tick();
        runs = 0; tpulses = 0; regrant = -1;
        for (int t = 0; t < 18; t++) begin
            tick();
            if (state == 2'd2) runs++;
            if (timeout) tpulses++;
            if (eng_start) regrant = int'(gnt_idx);
        end
        check_eq("to_runs", runs, TIMEOUT);
        check_eq("to_pulses", tpulses, 1);
        check_eq("to_cnt", 32'(timeout_cnt), 1);
        check_eq("to_regrant", regrant, 0);

        // Done on the same cycle as the timeout limit
        tick();
        for (int r = 1; r < TIMEOUT; r++) tick();
        check_eq("coll_in_run", 32'(state), 2);
        eng_done = 1'b1;
        tick();
        eng_done = 1'b0;
        check_eq("coll_state", 32'(state), 3);
        check_eq("coll_timeout", 32'(timeout), 0);
        check_eq("coll_tocnt", 32'(timeout_cnt), 1);
        req = '0;
        tick();

        // Request drop during RUN, then reset mid-run
        do_reset();
        req = 4'b0100;
        tick(); tick();
        req = '0;
        tick(); tick(); tick();
        check_eq("drop_gnt_held", 32'(gnt), 32'h4);
        rst = 1'b1; eng_done = 1'b1;
        tick();
        check_eq("midrst_state", 32'(state), 0);
        check_eq("midrst_gnt", 32'(gnt), 0);
        rst = 1'b0; req = 4'b1111;
        tick();
        eng_done = 1'b0;
        check_eq("midrst_idx", 32'(gnt_idx), 0);
        check_eq("midrst_gnt1", 32'(gnt), 32'h1);
        req = '0;
        for (int t = 0; t < 20; t++) tick();

        // Saturation of the timeout counter
        do_reset();
        req = 4'b0001; eng_done = 1'b0; tpulses = 0; guard = 0;
        while (tpulses < 260 && guard < 260 * (TIMEOUT + 3) + 50) begin
            tick();
            if (timeout) tpulses++;
            guard++;
        end
        check_eq("sat_pulses", tpulses, 260);
        check_eq("sat_cnt", 32'(timeout_cnt), 255);

        // Randomized traffic against the model
        do_reset();
        for (int t = 0; t < 4000; t++) begin
            if ($urandom_range(0, 3) == 0) req = NUM_REQ'($urandom_range(0, 15));
            eng_done = ($urandom_range(0, 3) == 0);
            rst      = ($urandom_range(0, 199) == 0);
            tick();
        end
        rst = 1'b0; eng_done = 1'b0; req = '0;

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
